clock_divider_bank: RTL and testbench
=====================================

Name: clock_divider_bank

Overview:
Parametrised, multi-channel successor to the free-running power-of-two clock divisor. Each channel divides clk by a run-time programmable integer (not only powers of two). Each channel produces a one-cycle tick (clock enable) and a 50%-duty square wave. Divide values change glitch-free at the terminal count. A common sync input phase-aligns all channels. Sits beside the top-level clock logic and feeds VGA, keypad-scan, audio and game-timer logic with clock enables instead of derived clocks.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 25, width of per-channel counter and divide value
DEFAULT_DIV, 1, divide value loaded into every channel at reset
CH_W, 2, width of load_ch; must satisfy 2**CH_W >= NUM_CH

Ports:
clk  input  1  single system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
ch_en  input  NUM_CH  per-channel run enable
sync  input  1  restart all channels in phase
load  input  1  one-cycle strobe: write load_div to channel load_ch
load_ch  input  CH_W  target channel for load
load_div  input  CNT_W  new divide value D; channel period is D+1 cycles
tick  output  NUM_CH  registered one-cycle pulse per channel period
clk_out  output  NUM_CH  registered square wave, period 2*(D+1) cycles
pending  output  NUM_CH  1 while a loaded value awaits its terminal count
free_cnt  output  CNT_W  free-running wrap-around counter (legacy power-of-two taps)

Behaviour:
- Reset (async, immediate): all cnt=0, div_active=DEFAULT_DIV, div_shadow=DEFAULT_DIV; tick, clk_out, pending, free_cnt all 0.
- free_cnt increments by 1 every cycle and wraps from 2**CNT_W-1 to 0. It is unaffected by sync, load and ch_en.
- Per channel, each edge, in priority order:
  1. ch_en=0: cnt<=0, tick<=0, clk_out<=0. A pending shadow is copied to div_active and pending clears.
  2. sync=1: cnt<=0, tick<=0, clk_out<=0. Shadow is applied if pending. Sync beats a coincident terminal count: no tick that edge.
  3. cnt==div_active (terminal count): cnt<=0, tick<=1, clk_out<=~clk_out. If pending, div_active<=div_shadow and pending<=0.
  4. Otherwise: cnt<=cnt+1, tick<=0.
- Timing: with D programmed and the channel enabled at edge 0, tick is high after edge D. It then repeats every D+1 cycles, with exactly one cycle high.
- D=0: tick is constantly 1 while enabled; clk_out toggles every cycle (clk/2).
- Load: on an edge with load=1 and load_ch<NUM_CH: div_shadow[load_ch]<=load_div and pending[load_ch]<=1.
  - The active period is never truncated or stretched mid-count.
  - A second load before the terminal count overwrites the shadow; the last value wins.
  - load_ch>=NUM_CH is ignored; no state changes.
- Load coincident with the terminal count on the same channel: the current period ends with the old div_active. The new value sits in the shadow, pending=1, and is applied at the next terminal count.
- The counter compares with ==. Because div_active only changes at cnt=0, cnt can never exceed div_active, and no wrap-around path exists.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-run: rst asserted asynchronously mid-cycle, no clock edge needed -> all outputs 0 immediately. After release, with ch_en=4'b0001 and DEFAULT_DIV=1 -> tick[0] high every 2nd cycle; clk_out[0] period 4.
- Program ch1 D=4, ch2 D=0, enable both -> tick[1] high every 5 cycles, first after edge 4; clk_out[1] period 10 at 50% duty; tick[2] constantly 1; clk_out[2] toggles each cycle.
- Ch0 at D=9; load D=2 when cnt=3 -> pending[0]=1. The current period still ends at cnt=9 with a tick. The next ticks are spaced 3 cycles apart; pending[0]=0 after the terminal count.
- Load coincident with terminal count: load D=7 on the same edge ch0 reaches cnt==div_active -> tick at the old period. pending stays 1; the new value takes effect one period later.
- Sync with ch0 D=3 and ch1 D=5 running out of phase; pulse sync on a ch0 terminal-count edge -> no tick[0] that edge. Both counters go to 0 with clk_out=0. Ticks then align every 12 cycles (LCM).
- Disable and edge cases: clear ch_en[1] while pending[1]=1 -> tick[1]/clk_out[1] 0 next edge and pending[1] clears. A load with load_ch=NUM_CH (when 2**CH_W>NUM_CH) changes nothing. free_cnt wraps to 0 after all-ones.

Source files
------------

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock-enable generator: each channel emits a one-cycle
// tick every D+1 cycles plus a 50% square wave, with glitch-free divide updates.
module clock_divider_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 25,
  parameter int DEFAULT_DIV = 1,
  parameter int CH_W        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] pending,
  output logic [CNT_W-1:0]  free_cnt
);

  logic [CNT_W-1:0]  cnt_q        [NUM_CH];
  logic [CNT_W-1:0]  cnt_d        [NUM_CH];
  logic [CNT_W-1:0]  div_active_q [NUM_CH];
  logic [CNT_W-1:0]  div_active_d [NUM_CH];
  logic [CNT_W-1:0]  div_shadow_q [NUM_CH];
  logic [CNT_W-1:0]  div_shadow_d [NUM_CH];
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]  free_cnt_q, free_cnt_d;
  logic              load_ok;

  assign load_ok = load && (int'(load_ch) < NUM_CH);

  always_comb begin
    free_cnt_d = free_cnt_q + CNT_W'(1);
    tick_d     = '0;
    clk_out_d  = clk_out_q;
    pending_d  = pending_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]        = cnt_q[i];
      div_active_d[i] = div_active_q[i];
      div_shadow_d[i] = div_shadow_q[i];
      // A new divide value may only take over when the counter restarts from zero,
      // so the running period is never cut short or stretched.
      if (!ch_en[i] || sync) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        if (pending_q[i]) begin
          div_active_d[i] = div_shadow_q[i];
          pending_d[i]    = 1'b0;
        end
      end else if (cnt_q[i] == div_active_q[i]) begin
        cnt_d[i]     = '0;
        tick_d[i]    = 1'b1;
        clk_out_d[i] = ~clk_out_q[i];
        if (pending_q[i]) begin
          div_active_d[i] = div_shadow_q[i];
          pending_d[i]    = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // A load landing on the terminal count stays queued for the following period.
      if (load_ok && (load_ch == CH_W'(i))) begin
        div_shadow_d[i] = load_div;
        pending_d[i]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]        <= '0;
        div_active_q[i] <= CNT_W'(DEFAULT_DIV);
        div_shadow_q[i] <= CNT_W'(DEFAULT_DIV);
      end
      tick_q     <= '0;
      clk_out_q  <= '0;
      pending_q  <= '0;
      free_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]        <= cnt_d[i];
        div_active_q[i] <= div_active_d[i];
        div_shadow_q[i] <= div_shadow_d[i];
      end
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
      pending_q  <= pending_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  assign tick     = tick_q;
  assign clk_out  = clk_out_q;
  assign pending  = pending_q;
  assign free_cnt = free_cnt_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank: stimulus queues the expected outputs for
// each clock edge, and a monitor compares them just after that edge.
module tb_clock_divider_bank;

  logic       clk, rst, sync, load;
  logic [3:0] ch_en, tick, clk_out, pending;
  logic [2:0] load_ch;
  logic [5:0] load_div, free_cnt;

  clock_divider_bank #(.NUM_CH(4), .CNT_W(6), .DEFAULT_DIV(1), .CH_W(3)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .sync(sync), .load(load),
    .load_ch(load_ch), .load_div(load_div), .tick(tick), .clk_out(clk_out),
    .pending(pending), .free_cnt(free_cnt)
  );

  typedef struct {
    string      name;
    logic [3:0] mask;
    logic [3:0] tk;
    logic [3:0] ck;
    logic [3:0] pd;
    logic [5:0] fr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   edges  = 0;

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, " tick"},     32'(tick & e.mask),    32'(e.tk & e.mask));
      chk({e.name, " clk_out"},  32'(clk_out & e.mask), 32'(e.ck & e.mask));
      chk({e.name, " pending"},  32'(pending),          32'(e.pd));
      chk({e.name, " free_cnt"}, 32'(free_cnt),         32'(e.fr));
    end
  end

  task automatic step(input string name, input logic [3:0] mask, input logic [3:0] t,
                      input logic [3:0] c, input logic [3:0] p);
    exp_t x;
    edges++;
    x.name = name; x.mask = mask; x.tk = t; x.ck = c; x.pd = p;
    x.fr = 6'(edges % 64);
    q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic run_default();
    logic t, c;
    c = 1'b0;
    ch_en = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      t = (k % 2 == 0);
      if (t) c = ~c;
      step("default_div", 4'hF, {3'b0, t}, {3'b0, c}, 4'b0);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " tick"},     32'(tick),     32'd0);
    chk({name, " clk_out"},  32'(clk_out),  32'd0);
    chk({name, " pending"},  32'(pending),  32'd0);
    chk({name, " free_cnt"}, 32'(free_cnt), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       t0, t1, t2, c0, c1, c2, p0;
    int         s0, s1;
    clk = 0; rst = 1; ch_en = 0; sync = 0; load = 0; load_ch = 0; load_div = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset_state");
    rst = 0; edges = 0;
    run_default();

    // asynchronous reset between clock edges
    #1; rst = 1; #1;
    chk_zero("async_reset");
    @(posedge clk); #2;
    rst = 0; edges = 0;
    run_default();

    ch_en = 4'b0000; load = 1; load_ch = 3'd1; load_div = 6'd4;
    step("prog_ch1", 4'hF, 4'b0, 4'b0, 4'b0010);
    load_ch = 3'd2; load_div = 6'd0;
    step("prog_ch2", 4'hF, 4'b0, 4'b0, 4'b0100);
    load = 0;
    step("prog_done", 4'hF, 4'b0, 4'b0, 4'b0000);
    ch_en = 4'b0110; c1 = 0; c2 = 0;
    for (int e = 0; e < 20; e++) begin
      t1 = (e % 5 == 4);
      t2 = 1'b1;
      if (t1) c1 = ~c1;
      c2 = ~c2;
      step("div4_div0", 4'hF, {1'b0, t2, t1, 1'b0}, {1'b0, c2, c1, 1'b0}, 4'b0);
    end

    ch_en = 4'b0000; load = 1; load_ch = 3'd0; load_div = 6'd9;
    step("prog_ch0_9", 4'hF, 4'b0, 4'b0, 4'b0001);
    load = 0;
    step("apply_ch0_9", 4'hF, 4'b0, 4'b0, 4'b0000);
    ch_en = 4'b0001; c0 = 0;
    for (int e = 0; e <= 40; e++) begin
      load = (e == 3 || e == 21);
      load_ch = 3'd0;
      load_div = (e == 3) ? 6'd2 : 6'd7;
      t0 = (e == 9 || e == 12 || e == 15 || e == 18 || e == 21 || e == 24 || e == 32 || e == 40);
      p0 = (e >= 3 && e < 9) || (e >= 21 && e < 24);
      if (t0) c0 = ~c0;
      step("shadow_load", 4'hF, {3'b0, t0}, {3'b0, c0}, {3'b0, p0});
    end
    load = 0;

    ch_en = 4'b0000; load = 1; load_ch = 3'd0; load_div = 6'd3;
    step("prog_ch0_3", 4'hF, 4'b0, 4'b0, 4'b0001);
    load_ch = 3'd1; load_div = 6'd5;
    step("prog_ch1_5", 4'hF, 4'b0, 4'b0, 4'b0010);
    load = 0;
    step("prog_sync_done", 4'hF, 4'b0, 4'b0, 4'b0000);
    c0 = 0; c1 = 0;
    for (int e = 0; e <= 40; e++) begin
      ch_en = (e == 0) ? 4'b0010 : ((e >= 35) ? 4'b0001 : 4'b0011);
      sync = (e == 8);
      load = (e == 34 || e == 36);
      load_ch = (e == 34) ? 3'd1 : 3'd4;
      load_div = (e == 34) ? 6'd2 : 6'd1;
      s0 = (e < 9) ? 1 : 9;
      s1 = (e < 9) ? 0 : 9;
      t0 = (e != 8) && (e >= s0) && ((e - s0) % 4 == 3);
      t1 = (e != 8) && (e < 35) && (e >= s1) && ((e - s1) % 6 == 5);
      if (e == 8) begin
        c0 = 0; c1 = 0;
      end
      if (t0) c0 = ~c0;
      if (t1) c1 = ~c1;
      if (e >= 35) c1 = 0;
      step("sync_disable", 4'hF, {2'b0, t1, t0}, {2'b0, c1, c0}, {2'b0, e == 34, 1'b0});
    end
    sync = 0; load = 0;

    @(posedge clk); #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
